// File: rtl/ecliptic_int2fp_pipe_if.sv
// Handshake bundle for the integer to binary32 converter.
// Master drives operations in and accepts results; slave is the converter.
interface ecliptic_int2fp_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_src;
  logic [2:0]       in_rm;
  logic             in_unsigned;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic             out_inexact;
  logic             out_rm_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_src, in_rm,
    output in_unsigned, in_tag, out_ready,
    input  in_ready, out_valid, out_res,
    input  out_inexact, out_rm_err, out_tag
  );

  modport slave (
    input  in_valid, in_src, in_rm,
    input  in_unsigned, in_tag, out_ready,
    output in_ready, out_valid, out_res,
    output out_inexact, out_rm_err, out_tag
  );
endinterface

// File: rtl/ecliptic_int2fp_pipe.sv
// Two-stage integer (32/64-bit, signed/unsigned) to IEEE-754 binary32
// converter with valid/ready flow control and all five rounding modes.
module ecliptic_int2fp_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  ecliptic_int2fp_pipe_if.slave bus
);
  localparam int LW = $clog2(XLEN);
  localparam logic [LW-1:0] TOP = LW'(XLEN-1);

  logic             s1_valid;
  logic             s1_sign;
  logic [XLEN-1:0]  s1_mag;
  logic [LW-1:0]    s1_lead;
  logic [2:0]       s1_rm;
  logic             s1_err;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [31:0]      s2_res;
  logic             s2_inexact;
  logic             s2_err;
  logic [TAG_W-1:0] s2_tag;

  logic s2_load;
  logic in_fire;

  always_comb begin
    s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    bus.in_ready = !rst && (!s1_valid || s2_load);
    in_fire      = bus.in_valid && bus.in_ready;
  end

  logic            sign_c;
  logic [XLEN:0]   ext_c;
  logic [XLEN-1:0] abs_c;
  logic [LW-1:0]   lead_c;
  logic            err_c;
  logic [2:0]      rm_c;

  // Negate in XLEN+1 bits so the most negative source is exact.
  always_comb begin
    sign_c = !bus.in_unsigned && bus.in_src[XLEN-1];
    ext_c  = {sign_c, bus.in_src};
    abs_c  = sign_c ? XLEN'(-ext_c) : bus.in_src;
    lead_c = '0;
    for (int i = 0; i < XLEN; i++)
      if (abs_c[i]) lead_c = LW'(i);
    err_c = bus.in_rm > 3'd4;
    rm_c  = err_c ? 3'd0 : bus.in_rm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_lead  <= '0;
      s1_rm    <= '0;
      s1_err   <= 1'b0;
      s1_tag   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_sign  <= sign_c;
      s1_mag   <= abs_c;
      s1_lead  <= lead_c;
      s1_rm    <= rm_c;
      s1_err   <= err_c;
      s1_tag   <= bus.in_tag;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  logic [XLEN-1:0] norm_c;
  logic [22:0]     frac_c;
  logic            g_c;
  logic            s_c;
  logic            inc_c;
  logic [31:0]     base_c;
  logic [31:0]     res_c;

  // Hidden bit lands at XLEN-1; it is clear only for a zero source.
  // A rounding carry ripples from fraction into exponent by itself.
  always_comb begin
    norm_c = s1_mag << (TOP - s1_lead);
    frac_c = norm_c[XLEN-2 -: 23];
    g_c    = norm_c[XLEN-25];
    s_c    = |norm_c[XLEN-26:0];
    case (s1_rm)
      3'd0:    inc_c = g_c && (s_c || frac_c[0]);
      3'd1:    inc_c = 1'b0;
      3'd2:    inc_c = s1_sign && (g_c || s_c);
      3'd3:    inc_c = !s1_sign && (g_c || s_c);
      default: inc_c = g_c;
    endcase
    base_c = {s1_sign, 8'd127 + 8'(s1_lead), frac_c};
    res_c  = norm_c[XLEN-1] ? base_c + 32'(inc_c) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_res     <= '0;
      s2_inexact <= 1'b0;
      s2_err     <= 1'b0;
      s2_tag     <= '0;
    end else if (s2_load) begin
      s2_valid   <= 1'b1;
      s2_res     <= res_c;
      s2_inexact <= g_c || s_c;
      s2_err     <= s1_err;
      s2_tag     <= s1_tag;
    end else if (bus.out_ready) begin
      s2_valid   <= 1'b0;
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_res     = s2_res;
  assign bus.out_inexact = s2_inexact;
  assign bus.out_rm_err  = s2_err;
  assign bus.out_tag     = s2_tag;
endmodule
